// File: rtl/jstk_multi_poller_if.sv
// Shared SPI bus to NUM_CH PmodJSTK joysticks: one SCLK/MOSI pair, one SS_n and one MISO per joystick.
// Latency: none, wires only.
// Backpressure: none; the master owns all timing and slaves only answer on miso.
// Ports: ss_n[NUM_CH] active-low selects, sclk idle-low clock, mosi master data, miso[NUM_CH] slave data.
interface jstk_multi_poller_if #(
   parameter int NUM_CH = 2
);
   logic [NUM_CH-1:0] ss_n;
   logic              sclk;
   logic              mosi;
   logic [NUM_CH-1:0] miso;

   modport master (output ss_n, output sclk, output mosi, input miso);
   modport slave  (input ss_n, input sclk, input mosi, output miso);
endinterface

// File: rtl/jstk_multi_poller.sv
// Round-robin poller: one SPI master reads NUM_CH PmodJSTK joysticks and decodes X/Y into direction flags.
// Latency: one 5-byte transaction per poll tick; outputs and sample_valid update the cycle after DONE.
// Backpressure: none; a poll tick that arrives while a transaction is in flight is dropped and sets sticky overrun.
// Ports: ClkPort/Reset (async, active-high); led[2*NUM_CH] LED command bits; spi master modport (ss_n, sclk, mosi, miso);
//        pos_x/pos_y[10*NUM_CH], btn[3*NUM_CH], up/down/left/right[NUM_CH]; sample_valid/sample_ch update strobe; overrun.
module jstk_multi_poller #(
   parameter int NUM_CH      = 2,
   parameter int SCLK_HALF   = 50,
   parameter int SS_SETUP    = 1500,
   parameter int BYTE_GAP    = 1000,
   parameter int POLL_CYCLES = 500000,
   parameter int THR_HI      = 630,
   parameter int THR_LO      = 300,
   parameter int HYST        = 16
) (
   input  logic                  ClkPort,
   input  logic                  Reset,
   input  logic [2*NUM_CH-1:0]   led,
   jstk_multi_poller_if.master   spi,
   output logic [10*NUM_CH-1:0]  pos_x,
   output logic [10*NUM_CH-1:0]  pos_y,
   output logic [3*NUM_CH-1:0]   btn,
   output logic [NUM_CH-1:0]     up,
   output logic [NUM_CH-1:0]     down,
   output logic [NUM_CH-1:0]     left,
   output logic [NUM_CH-1:0]     right,
   output logic                  sample_valid,
   output logic [2:0]            sample_ch,
   output logic                  overrun
);

   localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TMAX = (SCLK_HALF > SS_SETUP) ?
                         ((SCLK_HALF > BYTE_GAP) ? SCLK_HALF : BYTE_GAP) :
                         ((SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP);
   localparam int TW   = $clog2(TMAX + 1);
   localparam int PW   = $clog2(POLL_CYCLES + 1);

   // Thresholds widened once so every compare is plain unsigned 32-bit.
   localparam logic [31:0] R_SET = 32'(THR_HI);
   localparam logic [31:0] R_CLR = 32'(THR_HI - HYST);
   localparam logic [31:0] L_SET = 32'(THR_LO);
   localparam logic [31:0] L_CLR = 32'(THR_LO + HYST);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_HOLD, S_DONE} state_t;

   state_t          state_q, state_nxt;
   logic [TW-1:0]   tmr_q;
   logic [PW-1:0]   poll_q;
   logic [CW-1:0]   ch_q;
   logic [2:0]      bit_q;
   logic [2:0]      byte_q;
   logic            sclk_q;
   logic [7:0]      tx_sr;
   logic [7:0]      rx_sr;
   logic [7:0]      x_lo, y_lo;
   logic [1:0]      x_hi, y_hi;
   logic [2:0]      rx_btn;
   logic [NUM_CH-1:0] ss_n_q;

   logic [9:0]      pos_x_r [NUM_CH];
   logic [9:0]      pos_y_r [NUM_CH];
   logic [2:0]      btn_r   [NUM_CH];
   logic [1:0]      led_ch  [NUM_CH];

   logic            tick, start, tmr_clr, sclk_rise, sclk_fall, byte_end;
   logic [31:0]     x32, y32;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign pos_x[10*i +: 10] = pos_x_r[i];
      assign pos_y[10*i +: 10] = pos_y_r[i];
      assign btn[3*i +: 3]     = btn_r[i];
      assign led_ch[i]         = led[2*i +: 2];
   end

   assign tick     = (poll_q == PW'(POLL_CYCLES - 1));
   assign spi.sclk = sclk_q;
   assign spi.ss_n = ss_n_q;
   // Data only appears on the bus while shifting; it changes on falling edges so it is stable around each rise.
   assign spi.mosi = (state_q == S_SHIFT) && tx_sr[7];

   assign x32 = 32'({x_hi, x_lo});
   assign y32 = 32'({y_hi, y_lo});

   // Set wins, then clear, otherwise keep: values in the hysteresis band hold the previous flag.
   function automatic logic hyst(input logic prev, input logic set_c, input logic clr_c);
      return set_c ? 1'b1 : (clr_c ? 1'b0 : prev);
   endfunction

   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) state_q <= S_IDLE;
      else       state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      start     = 1'b0;
      tmr_clr   = 1'b0;
      sclk_rise = 1'b0;
      sclk_fall = 1'b0;
      byte_end  = 1'b0;
      case (state_q)
         S_IDLE: begin
            tmr_clr = 1'b1;
            if (tick) begin
               start     = 1'b1;
               state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            if (tmr_q == TW'(SS_SETUP - 1)) begin
               tmr_clr   = 1'b1;
               state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (tmr_q == TW'(SCLK_HALF - 1)) begin
               tmr_clr = 1'b1;
               if (!sclk_q) begin
                  sclk_rise = 1'b1;
               end else begin
                  sclk_fall = 1'b1;
                  if (bit_q == 3'd7) begin
                     byte_end  = 1'b1;
                     state_nxt = (byte_q == 3'd4) ? S_HOLD : S_GAP;
                  end
               end
            end
         end
         S_GAP: begin
            if (tmr_q == TW'(BYTE_GAP - 1)) begin
               tmr_clr   = 1'b1;
               state_nxt = S_SHIFT;
            end
         end
         S_HOLD: begin
            if (tmr_q == TW'(SS_SETUP - 1)) begin
               tmr_clr   = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            tmr_clr   = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         tmr_q        <= '0;
         poll_q       <= '0;
         ch_q         <= '0;
         bit_q        <= '0;
         byte_q       <= '0;
         sclk_q       <= 1'b0;
         tx_sr        <= '0;
         rx_sr        <= '0;
         x_lo         <= '0;
         y_lo         <= '0;
         x_hi         <= '0;
         y_hi         <= '0;
         rx_btn       <= '0;
         ss_n_q       <= '1;
         up           <= '0;
         down         <= '0;
         left         <= '0;
         right        <= '0;
         sample_valid <= 1'b0;
         sample_ch    <= '0;
         overrun      <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            pos_x_r[i] <= '0;
            pos_y_r[i] <= '0;
            btn_r[i]   <= '0;
         end
      end else begin
         poll_q <= tick ? '0 : poll_q + 1'b1;
         tmr_q  <= tmr_clr ? '0 : tmr_q + 1'b1;
         if (tick && (state_q != S_IDLE)) overrun <= 1'b1;

         // Select follows the next state so it drops with SETUP entry and rises with DONE entry.
         if ((state_nxt == S_SETUP) || (state_nxt == S_SHIFT) ||
             (state_nxt == S_GAP)   || (state_nxt == S_HOLD))
            ss_n_q <= ~(NUM_CH'(1) << ch_q);
         else
            ss_n_q <= '1;

         if (start) begin
            tx_sr  <= {6'b100000, led_ch[ch_q]};
            bit_q  <= '0;
            byte_q <= '0;
         end
         if (sclk_rise) begin
            sclk_q <= 1'b1;
            rx_sr  <= {rx_sr[6:0], spi.miso[ch_q]};
         end
         if (sclk_fall) begin
            sclk_q <= 1'b0;
            tx_sr  <= {tx_sr[6:0], 1'b0};
            bit_q  <= bit_q + 1'b1;
         end
         if (byte_end) begin
            byte_q <= byte_q + 1'b1;
            case (byte_q)
               3'd0:    x_lo   <= rx_sr;
               3'd1:    x_hi   <= rx_sr[1:0];
               3'd2:    y_lo   <= rx_sr;
               3'd3:    y_hi   <= rx_sr[1:0];
               default: rx_btn <= rx_sr[2:0];
            endcase
         end

         sample_valid <= (state_q == S_DONE);
         if (state_q == S_DONE) begin
            pos_x_r[ch_q] <= {x_hi, x_lo};
            pos_y_r[ch_q] <= {y_hi, y_lo};
            btn_r[ch_q]   <= rx_btn;
            right[ch_q]   <= hyst(right[ch_q], x32 >= R_SET, x32 < R_CLR);
            left[ch_q]    <= hyst(left[ch_q],  x32 <= L_SET, x32 > L_CLR);
            up[ch_q]      <= hyst(up[ch_q],    y32 >= R_SET, y32 < R_CLR);
            down[ch_q]    <= hyst(down[ch_q],  y32 <= L_SET, y32 > L_CLR);
            sample_ch     <= 3'(ch_q);
            ch_q          <= (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_jstk_multi_poller.sv
module tb_jstk_multi_poller;
   localparam int NCH = 2, SH = 2, SSU = 4, GAPC = 4, PC = 400, PCB = 50;
   localparam int THI = 630, TLO = 300, HY = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2*NCH-1:0]  led = '0;
   logic [2*NCH-1:0]  led_b = '0;
   logic [10*NCH-1:0] pos_x_a, pos_y_a, pos_x_b, pos_y_b;
   logic [3*NCH-1:0]  btn_a, btn_b;
   logic [NCH-1:0]    up_a, down_a, left_a, right_a, up_b, down_b, left_b, right_b;
   logic              sv_a, sv_b, ovr_a, ovr_b;
   logic [2:0]        sch_a, sch_b;

   jstk_multi_poller_if #(.NUM_CH(NCH)) spi_a ();
   jstk_multi_poller_if #(.NUM_CH(NCH)) spi_b ();
   assign spi_b.miso = '1;

   jstk_multi_poller #(.NUM_CH(NCH), .SCLK_HALF(SH), .SS_SETUP(SSU), .BYTE_GAP(GAPC),
                       .POLL_CYCLES(PC), .THR_HI(THI), .THR_LO(TLO), .HYST(HY)) dut_a (
      .ClkPort(clk), .Reset(rst), .led(led), .spi(spi_a),
      .pos_x(pos_x_a), .pos_y(pos_y_a), .btn(btn_a),
      .up(up_a), .down(down_a), .left(left_a), .right(right_a),
      .sample_valid(sv_a), .sample_ch(sch_a), .overrun(ovr_a));

   jstk_multi_poller #(.NUM_CH(NCH), .SCLK_HALF(SH), .SS_SETUP(SSU), .BYTE_GAP(GAPC),
                       .POLL_CYCLES(PCB), .THR_HI(THI), .THR_LO(TLO), .HYST(HY)) dut_b (
      .ClkPort(clk), .Reset(rst), .led(led_b), .spi(spi_b),
      .pos_x(pos_x_b), .pos_y(pos_y_b), .btn(btn_b),
      .up(up_b), .down(down_b), .left(left_b), .right(right_b),
      .sample_valid(sv_b), .sample_ch(sch_b), .overrun(ovr_b));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Joystick slave model: answers a 40-bit frame on MISO and records the 40 MOSI bits.
   logic [9:0]  rx_x [NCH];
   logic [9:0]  rx_y [NCH];
   logic [2:0]  rx_b [NCH];
   int          act = -1;
   int          bitn = 0;
   int          rises = 0;
   logic [39:0] frame = '0;
   logic [39:0] mosi_sr = '0;
   logic [39:0] mosi_last = '0;
   int          ch_log[$];
   bit          ss_bad = 1'b0;
   logic        sclk_prev = 1'b0;

   always @(negedge clk) begin
      if ($countones(~spi_a.ss_n) > 1) ss_bad = 1'b1;
      if (act < 0 && spi_a.ss_n != 2'b11) begin
         act   = (spi_a.ss_n[0] == 1'b0) ? 0 : 1;
         frame = {rx_x[act][7:0], 6'b0, rx_x[act][9:8], rx_y[act][7:0], 6'b0, rx_y[act][9:8], 5'b0, rx_b[act]};
         bitn = 0; rises = 0; mosi_sr = '0;
      end else if (act >= 0 && spi_a.ss_n == 2'b11) begin
         if (rises == 40) begin
            mosi_last = mosi_sr;
            ch_log.push_back(act);
         end
         act = -1;
      end else if (act >= 0) begin
         if (spi_a.sclk && !sclk_prev) begin
            mosi_sr = {mosi_sr[38:0], spi_a.mosi};
            rises++;
         end
         if (!spi_a.sclk && sclk_prev) bitn++;
      end
      spi_a.miso = '0;
      if (act >= 0 && bitn < 40) spi_a.miso[act] = frame[39-bitn];
      sclk_prev = spi_a.sclk;
   end

   // Reference model: latest sample and direction flags per channel.
   logic [9:0] mx [NCH];
   logic [9:0] my [NCH];
   logic [2:0] mb [NCH];
   logic       mu [NCH], md [NCH], ml [NCH], mr [NCH];

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         mx[i] = '0; my[i] = '0; mb[i] = '0;
         mu[i] = 1'b0; md[i] = 1'b0; ml[i] = 1'b0; mr[i] = 1'b0;
      end
   endtask

   function automatic logic [9:0] rnd10();
      case ($urandom_range(0, 2))
         0:       return 10'($urandom_range(0, 1023));
         1:       return 10'($urandom_range(600, 650));
         default: return 10'($urandom_range(280, 330));
      endcase
   endfunction

   task automatic do_txn(input int c, input logic [9:0] x, input logic [9:0] y,
                         input logic [2:0] b, input logic [3:0] l);
      bit ok;
      int nlog, got;
      logic [19:0] ex, ey;
      logic [5:0]  eb;
      logic [1:0]  eu, ed, el, er;
      logic [1:0]  lsel;
      rx_x[c] = x; rx_y[c] = y; rx_b[c] = b; led = l;
      nlog = ch_log.size();
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (sv_a) begin ok = 1'b1; break; end
      end
      chk("txn_seen", ok, 1);
      chk("sample_ch", sch_a, c);
      got = (ch_log.size() > nlog) ? ch_log[ch_log.size()-1] : -1;
      chk("ss_channel", got, c);
      lsel = l[2*c +: 2];
      chk("mosi_frame", mosi_last, {6'b100000, lsel, 32'h0});
      mx[c] = x; my[c] = y; mb[c] = b;
      mr[c] = (x >= THI) ? 1'b1 : ((x < THI - HY) ? 1'b0 : mr[c]);
      ml[c] = (x <= TLO) ? 1'b1 : ((x > TLO + HY) ? 1'b0 : ml[c]);
      mu[c] = (y >= THI) ? 1'b1 : ((y < THI - HY) ? 1'b0 : mu[c]);
      md[c] = (y <= TLO) ? 1'b1 : ((y > TLO + HY) ? 1'b0 : md[c]);
      for (int i = 0; i < NCH; i++) begin
         ex[10*i +: 10] = mx[i]; ey[10*i +: 10] = my[i]; eb[3*i +: 3] = mb[i];
         eu[i] = mu[i]; ed[i] = md[i]; el[i] = ml[i]; er[i] = mr[i];
      end
      chk("pos_x", pos_x_a, ex);
      chk("pos_y", pos_y_a, ey);
      chk("btn", btn_a, eb);
      chk("up", up_a, eu);
      chk("down", down_a, ed);
      chk("left", left_a, el);
      chk("right", right_a, er);
      @(negedge clk);
      chk("sv_one_cycle", sv_a, 0);
      chk("sch_hold", sch_a, c);
   endtask

   initial begin
      bit ok;
      int c;
      model_reset();
      rx_x[0] = 10'd700; rx_y[0] = 10'd512; rx_b[0] = 3'b101;
      rx_x[1] = 10'd100; rx_y[1] = 10'd900; rx_b[1] = 3'b010;
      led = 4'b0011;
      repeat (3) @(negedge clk);
      chk("rst_ss_n", spi_a.ss_n, 2'b11);
      chk("rst_sclk", spi_a.sclk, 0);
      chk("rst_mosi", spi_a.mosi, 0);
      chk("rst_pos", {pos_x_a, pos_y_a, btn_a}, 0);
      chk("rst_flags", {up_a, down_a, left_a, right_a}, 0);
      chk("rst_sv", {sv_a, sch_a, ovr_a}, 0);
      chk("rst_ovr_b", ovr_b, 0);
      rst = 1'b0;

      // Short poll period: second tick lands mid-transaction.
      repeat (75) @(negedge clk);
      chk("ovr_b_first_tick", ovr_b, 0);
      repeat (30) @(negedge clk);
      chk("ovr_b_second_tick", ovr_b, 1);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (sv_b) begin ok = 1'b1; break; end
      end
      chk("b_txn_seen", ok, 1);
      chk("b_sample_ch", sch_b, 0);
      chk("b_pos", {pos_x_b[9:0], pos_y_b[9:0], btn_b[2:0]}, {10'd1023, 10'd1023, 3'd7});
      chk("b_flags", {up_b[0], down_b[0], left_b[0], right_b[0]}, 4'b1001);

      // First transaction, channel 0, LED bits 11.
      do_txn(0, 10'd700, 10'd512, 3'b101, 4'b0011);
      chk("t1_x", pos_x_a[9:0], 700);
      chk("t1_flags", {right_a[0], left_a[0], up_a[0], down_a[0]}, 4'b1000);
      chk("t1_btn", btn_a[2:0], 5);

      // Channel alternation and hysteresis sequence on channel 0.
      do_txn(1, rnd10(), rnd10(), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      do_txn(0, 10'd640, 10'd290, 3'd0, 4'b0000);
      chk("t4_a", {right_a[0], down_a[0]}, 2'b11);
      do_txn(1, rnd10(), rnd10(), 3'd1, 4'b1000);
      do_txn(0, 10'd620, 10'd310, 3'd2, 4'b0001);
      chk("t4_b", {right_a[0], down_a[0]}, 2'b11);
      do_txn(1, rnd10(), rnd10(), 3'd3, 4'b0100);
      do_txn(0, 10'd613, 10'd317, 3'd4, 4'b0010);
      chk("t4_c", {right_a[0], down_a[0]}, 2'b00);

      c = 1;
      for (int n = 0; n < 10; n++) begin
         do_txn(c, rnd10(), rnd10(), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
         c = 1 - c;
      end
      chk("ss_one_hot", ss_bad, 0);
      chk("a_no_overrun", ovr_a, 0);

      // Reset in the middle of byte 2.
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (act >= 0 && rises >= 18) begin ok = 1'b1; break; end
      end
      chk("reach_byte2", ok, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ss_n", spi_a.ss_n, 2'b11);
      chk("mid_rst_sclk", {spi_a.sclk, spi_a.mosi}, 0);
      chk("mid_rst_pos", {pos_x_a, pos_y_a, btn_a}, 0);
      chk("mid_rst_flags", {up_a, down_a, left_a, right_a, sv_a, ovr_b}, 0);
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      do_txn(0, rnd10(), rnd10(), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      do_txn(1, rnd10(), rnd10(), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jstk_multi_poller.md
Name: jstk_multi_poller

Overview:
- Parametrised successor to the single-joystick input path: one shared SPI master that polls NUM_CH PmodJSTK joysticks round-robin.
- Decodes each channel's 10-bit X/Y into UP/DOWN/LEFT/RIGHT flags using programmable thresholds with hysteresis, and forwards LED commands.
- Sits between the board pins and game_logic; replaces per-player fixed-threshold decode and the separate send/receive clock.

Parameters:
NUM_CH, 2, number of joysticks (1..8); shared SCLK/MOSI, one SS_n and MISO each
SCLK_HALF, 50, ClkPort cycles per SCLK half-period (1 MHz at 100 MHz)
SS_SETUP, 1500, cycles from SS_n low to first SCLK edge, and from last bit to SS_n high
BYTE_GAP, 1000, idle cycles between bytes
POLL_CYCLES, 500000, cycles between transaction starts (200 Hz)
THR_HI, 630, assert threshold for RIGHT (X) / UP (Y)
THR_LO, 300, assert threshold for LEFT (X) / DOWN (Y)
HYST, 16, release hysteresis in counts

Ports:
ClkPort  in  1  system clock, 100 MHz
Reset  in  1  asynchronous, active-high reset
led  in  2*NUM_CH  LED bits per channel, sent in command byte
miso  in  NUM_CH  per-channel MISO
ss_n  out  NUM_CH  per-channel slave select, active low
sclk  out  1  shared serial clock, idle low
mosi  out  1  shared master-out
pos_x  out  10*NUM_CH  latest X per channel
pos_y  out  10*NUM_CH  latest Y per channel
btn  out  3*NUM_CH  latest button bits [2:0] per channel
up, down, left, right  out  NUM_CH each  decoded direction flags
sample_valid  out  1  one-cycle pulse when a channel's outputs update
sample_ch  out  3  channel index of the update
overrun  out  1  sticky: a poll tick arrived while busy

Behaviour:
- Reset (async, any state, including mid-transfer): ss_n all 1, sclk 0, mosi 0, all pos/btn/direction outputs 0, sample_valid 0, sample_ch 0, overrun 0, channel pointer 0, poll counter 0, FSM IDLE.
- Poll counter counts 0..POLL_CYCLES-1 and wraps; a wrap is a tick.
  - Tick in IDLE: start a transaction on the current channel.
  - Tick in any other state: dropped, overrun set to 1 (cleared only by reset).
- FSM:
  - IDLE -> SETUP on tick; ss_n[ch] goes low.
  - SETUP: wait SS_SETUP cycles -> SHIFT.
  - SHIFT: 8 bits, MSB first, SPI mode 0. mosi is driven while sclk is low; miso[ch] is sampled on the sclk rising edge; each half-period is SCLK_HALF cycles. After the 8th falling edge: bytes 0..3 -> GAP, byte 4 -> HOLD.
  - GAP: BYTE_GAP cycles with sclk low -> SHIFT.
  - HOLD: SS_SETUP cycles -> DONE; ss_n[ch] high on entry to DONE.
  - DONE (1 cycle): update outputs, pulse sample_valid, advance ch (NUM_CH-1 wraps to 0) -> IDLE.
- TX bytes: byte0 = {6'b100000, led[2ch+1:2ch]}; bytes 1..4 = 0x00.
- RX bytes: b0 X[7:0], b1 X[9:8] in bits [1:0], b2 Y[7:0], b3 Y[9:8] in bits [1:0], b4 buttons in bits [2:0].
- Other channels' outputs hold during a transaction. Only one ss_n is ever low.
- Hysteresis decode, evaluated in DONE on the new sample, unsigned 10-bit compare:
  - right: set when X >= THR_HI; clear when X < THR_HI-HYST; else hold.
  - left: set when X <= THR_LO; clear when X > THR_LO+HYST; else hold.
  - up/down: same rules on Y.
  - A value in a hysteresis band keeps the previous flag.
- sample_valid: exactly one cycle per completed transaction; sample_ch equals the channel just polled. sample_ch is valid with sample_valid and holds afterwards.
- Transaction length must be shorter than POLL_CYCLES for overrun-free operation; the block does not check this.

Test Plan:
Use NUM_CH=2, SCLK_HALF=2, SS_SETUP=4, BYTE_GAP=4, POLL_CYCLES=400 unless stated.
1. Reset, then run -> first tick lowers ss_n=2'b10. Model returns X=700, Y=512, btn=3'b101 -> in DONE: pos_x[9:0]=700, right=1, left=0, up=0, down=0, btn[2:0]=5; sample_valid pulses 1 cycle with sample_ch=0.
2. Second tick -> ss_n=2'b01 (channel 1). Third tick -> channel 0 again (wrap). ss_n is never 2'b00.
3. led[1:0]=2'b11 -> first MOSI byte captured by model = 0x83; remaining four bytes = 0x00.
4. Channel 0 X sequence 640, 620, 613 -> right = 1, 1 (hold, inside band), 0 (613 < 614). Y sequence 290, 310, 317 -> down = 1, 1, 0.
5. POLL_CYCLES=50 (shorter than a transaction) -> overrun=1 after the second tick; transactions still complete correctly.
6. Assert Reset in SHIFT of byte 2 -> immediately ss_n=2'b11, sclk=0, all outputs 0. Release -> next transaction starts on channel 0 at the first tick.
